multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the LEGv8 datapath (register file, ALU, data SRAM).
- Fetches each instruction over an imem handshake and latches it in an instruction register (IR).
- Steps FETCH/DECODE/EXEC/MEM/WB and drives the register-file, ALU, B-mux, D-mux and SRAM controls from registered state.
- Owns the PC and the latched condition flags, which replaces clock-level gating of control signals.

Parameters:
- PC_W, 32, PC and byte-address width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  allows leaving FETCH; when low, the block idles in FETCH.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_ready  in  1  instr is valid this cycle.
- instr  in  32  instruction word.
- pc  out  PC_W  current PC.
- read1_addr, read2_addr, write_addr  out  5 each  register-file addresses.
- write_en  out  1  register-file write strobe.
- rd1_data  in  64  register-file read port 1 data, used by BR.
- alu_function  out  3  ALU operation select.
- FLAGS  in  4  ALU flags {N,Z,C,V}.
- Bselect  out  1  B-bus select: 0 = register, 1 = constant.
- constant  out  32  zero-extended shamt or DT_address.
- Dselect  out  1  data-out select: 1 = SRAM, 0 = ALU.
- SRAM_CS, SRAM_write, writeToSRAM  out  1 each  SRAM controls.
- sram_ready  in  1  SRAM access complete.
- illegal  out  1  one-cycle pulse when an unrecognised opcode is decoded.

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, IR=0, flag_reg=0. Every output is 0 except imem_addr, which equals pc.
- Decode classes (taken from IR):
  - R-type on IR[31:21]: ADD 458h, SUB 658h, AND 450h, ORR 550h, EOR 650h, LSL 69Bh.
  - Memory on IR[31:21]: LDURSW 5C4h, STURW 5C0h.
  - BR on IR[31:21] = 6B0h.
  - B on IR[31:26] = 000101b.
  - B.cond on IR[31:24] = 01010100b.
  - Anything else, including an all-zero word, is NOP/illegal.
- Fields: Rd=IR[4:0], Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16], shamt=IR[15:10], DT=IR[20:12], imm26=IR[25:0], imm19=IR[23:5], cond=IR[3:0].
- ALU codes: PASS 000, ADD 001, SUB 010, AND 011, ORR 100, EOR 101, LSL 110.
- FETCH:
  - imem_req=run.
  - On run && imem_ready: IR<=instr, go to DECODE.
  - While imem_ready is low, hold imem_req and address.
- DECODE (1 cycle):
  - Set read1_addr=Rn for all classes except BR, which sets read1_addr=Rt.
  - Set read2_addr=Rm for R-type, Rt for STURW.
  - NOP/illegal: illegal=1, pc<=pc+4, go to FETCH.
  - All other classes go to EXEC.
- EXEC (1 cycle): drive alu_function, Bselect and constant.
  - LSL: Bselect=1, constant=shamt.
  - LDURSW/STURW: Bselect=1, constant=DT, ADD.
  - R-type: go to WB.
  - ADD/SUB: flag_reg<=FLAGS at the end of EXEC; no other instruction updates the flags.
  - B: pc<=pc+sext(imm26)<<2.
  - B.cond: pc<=pc+sext(imm19)<<2 if taken, else pc+4.
  - BR: pc<=rd1_data[PC_W-1:0].
  - Branches then go to FETCH.
  - Memory: go to MEM.
- Condition evaluation uses flag_reg, not the live FLAGS:
  - EQ(0) Z; NE(1) !Z; GE(A) N==V; LT(B) N!=V; GT(C) !Z&&N==V; LE(D) Z||N!=V.
  - All other cond values are not taken.
- MEM: SRAM_CS=1 and the ALU address is held.
  - LDURSW: Dselect=1.
  - STURW: writeToSRAM=1 and SRAM_write=1.
  - Stay in MEM until sram_ready (minimum 1 cycle).
  - STURW: on sram_ready, pc<=pc+4, go to FETCH.
  - LDURSW: on sram_ready, go to WB.
- WB (1 cycle): write_en=1, write_addr=Rd for R-type or Rt for LDURSW; Dselect=1 for LDURSW; pc<=pc+4; go to FETCH.
- Strobe rules:
  - write_en, SRAM_write and illegal are high only in their stated state and 0 elsewhere.
  - Outputs not listed for a state hold 0; addresses hold their last value.
- Latency (imem_ready/sram_ready immediate): R-type 4 cycles, LDURSW 5, STURW 4, branch 3, NOP 2.
- PC arithmetic is modulo 2^PC_W; wrap-around is legal.
- run low only blocks leaving FETCH; an instruction in flight completes.
- rst_n low in any state: next cycle reset values apply, and a pending SRAM access is abandoned (CS drops).

Decomposition:
- Package legv8_ctrl_pkg: opcode constants, ALU codes, cond codes, state enum {FETCH, DECODE, EXEC, MEM, WB}.
- Sub-module instr_decode: combinational IR → class, fields, alu_function, sign-extended offsets.
- The sequencer instantiates instr_decode and holds the FSM, pc, IR and flag_reg.

Test Plan:
- Reset mid-MEM during STURW with sram_ready=0 -> next cycle state FETCH, pc=0, SRAM_CS=0, SRAM_write=0.
- ADD X3,X1,X2 (8B020023h), both readies tied high -> read1=1, read2=2, alu=001, write_en high one cycle in cycle 4 with write_addr=3, pc 0→4.
- LDURSW X5,[X1,#8] with sram_ready delayed 3 cycles -> SRAM_CS high 3 cycles, Dselect=1, constant=8, write_en in the following cycle, total 7 cycles.
- SUB with FLAGS=0000, then B.cond GT with imm19=4 -> pc=pc_branch+16; repeat with FLAGS=0100 -> pc+4.
- B with imm26=3FFFFFFh at pc=10h -> pc=0Ch. BR with rd1_data=40h -> pc=40h. Neither asserts write_en.
- Word 00000000h, then unknown word FFFFFFFFh -> illegal pulses once each, pc advances by 4 each, no write_en or SRAM_CS.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared constants and types for the LEGv8 multi-cycle sequencer.
// Opcode constants, ALU function codes, branch condition codes, FSM state and
// instruction-class enums, the decoded-instruction payload, and the branch
// condition evaluator.
package legv8_ctrl_pkg;

  localparam int unsigned OPC11_W = 11;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 6;
  localparam int unsigned DT_W    = 9;

  // 11-bit opcodes at IR[31:21]
  localparam logic [OPC11_W-1:0] OP_ADD    = 11'h458;
  localparam logic [OPC11_W-1:0] OP_SUB    = 11'h658;
  localparam logic [OPC11_W-1:0] OP_AND    = 11'h450;
  localparam logic [OPC11_W-1:0] OP_ORR    = 11'h550;
  localparam logic [OPC11_W-1:0] OP_EOR    = 11'h650;
  localparam logic [OPC11_W-1:0] OP_LSL    = 11'h69B;
  localparam logic [OPC11_W-1:0] OP_LDURSW = 11'h5C4;
  localparam logic [OPC11_W-1:0] OP_STURW  = 11'h5C0;
  localparam logic [OPC11_W-1:0] OP_BR     = 11'h6B0;

  // Short opcodes: B at IR[31:26], B.cond at IR[31:24]
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_ORR  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_EOR  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_LSL  = 3'b110;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LDUR  = 3'd2,
    CLS_STUR  = 3'd3,
    CLS_BR    = 3'd4,
    CLS_B     = 3'd5,
    CLS_BCOND = 3'd6
  } instr_class_e;

  // Decoded instruction; rd doubles as Rt since both live in IR[4:0].
  typedef struct packed {
    instr_class_e        cls;
    logic [ALU_W-1:0]    alu_fn;
    logic                sets_flags;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rn;
    logic [REG_W-1:0]    rm;
    logic [SHAMT_W-1:0]  shamt;
    logic [DT_W-1:0]     dt;
    logic [COND_W-1:0]   cond;
  } dec_t;

  // Branch condition evaluation on latched N, Z, V.
  function automatic logic cond_taken(input logic n, input logic z, input logic v,
                                      input logic [COND_W-1:0] cond);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational LEGv8 instruction decoder.
// Ports: ir_i        - instruction word
//        dec_o       - class, register fields, immediates, ALU function
//        off_b_o     - sext(imm26) << 2, truncated to PC_W
//        off_bcond_o - sext(imm19) << 2, truncated to PC_W
module instr_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [31:0]     ir_i,
  output dec_t            dec_o,
  output logic [PC_W-1:0] off_b_o,
  output logic [PC_W-1:0] off_bcond_o
);

  logic [OPC11_W-1:0] op11;
  logic signed [27:0] b_byte_off;
  logic signed [20:0] bc_byte_off;

  assign op11        = ir_i[31:21];
  assign b_byte_off  = {ir_i[25:0], 2'b00};
  assign bc_byte_off = {ir_i[23:5], 2'b00};

  // Signed size casts sign-extend the byte offsets to the PC width.
  assign off_b_o     = PC_W'(b_byte_off);
  assign off_bcond_o = PC_W'(bc_byte_off);

  // Class and ALU function; 11-bit opcodes first, then the short B/B.cond forms.
  always_comb begin
    dec_o            = '0;
    dec_o.cls        = CLS_NOP;
    dec_o.alu_fn     = ALU_PASS;
    dec_o.sets_flags = 1'b0;
    dec_o.rd         = ir_i[4:0];
    dec_o.rn         = ir_i[9:5];
    dec_o.rm         = ir_i[20:16];
    dec_o.shamt      = ir_i[15:10];
    dec_o.dt         = ir_i[20:12];
    dec_o.cond       = ir_i[3:0];
    case (op11)
      OP_ADD:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_ADD; dec_o.sets_flags = 1'b1; end
      OP_SUB:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_SUB; dec_o.sets_flags = 1'b1; end
      OP_AND:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_AND; end
      OP_ORR:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_ORR; end
      OP_EOR:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_EOR; end
      OP_LSL:    begin dec_o.cls = CLS_RTYPE; dec_o.alu_fn = ALU_LSL; end
      OP_LDURSW: begin dec_o.cls = CLS_LDUR;  dec_o.alu_fn = ALU_ADD; end
      OP_STURW:  begin dec_o.cls = CLS_STUR;  dec_o.alu_fn = ALU_ADD; end
      OP_BR:     dec_o.cls = CLS_BR;
      default: begin
        if (ir_i[31:26] == OP_B) begin
          dec_o.cls = CLS_B;
        end else if (ir_i[31:24] == OP_BCOND) begin
          dec_o.cls = CLS_BCOND;
        end
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM.
// Ports: clk, rst_n (sync, active-low), run (permits leaving FETCH);
//        imem_req/imem_addr/imem_ready/instr - instruction fetch handshake;
//        pc - current PC; read1/read2/write_addr, write_en, rd1_data - regfile;
//        alu_function, FLAGS, Bselect, constant - ALU side;
//        Dselect, SRAM_CS, SRAM_write, writeToSRAM, sram_ready - data SRAM;
//        illegal - one-cycle pulse on an unrecognised opcode.
// All control outputs are registered and describe the current state.
module multicycle_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       instr,
  output logic [PC_W-1:0]   pc,
  output logic [4:0]        read1_addr,
  output logic [4:0]        read2_addr,
  output logic [4:0]        write_addr,
  output logic              write_en,
  input  logic [63:0]       rd1_data,
  output logic [2:0]        alu_function,
  input  logic [3:0]        FLAGS,
  output logic              Bselect,
  output logic [31:0]       constant,
  output logic              Dselect,
  output logic              SRAM_CS,
  output logic              SRAM_write,
  output logic              writeToSRAM,
  input  logic              sram_ready,
  output logic              illegal
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      ir_q;
  logic [31:0]      ir_d;
  logic [3:0]       flag_q;
  logic             imem_req_q;
  logic [4:0]       read1_q, read2_q, write_addr_q;
  logic             write_en_q;
  logic [2:0]       alu_q;
  logic             bsel_q;
  logic [31:0]      const_q;
  logic             dsel_q, cs_q, sram_wr_q, to_sram_q, illegal_q;

  logic             fetch_acc;
  logic             is_mem;
  logic             mem_stay;
  logic             bc_taken;
  logic [PC_W-1:0]  pc_plus4;
  dec_t             dec;
  logic [PC_W-1:0]  off_b, off_bc;
  logic             unused_bits;

  // Decode the word being latched on the accept cycle so DECODE-state outputs
  // are ready on DECODE entry; elsewhere this is just the IR.
  assign fetch_acc = (state_q == FETCH) && run && imem_ready;
  assign ir_d      = fetch_acc ? instr : ir_q;

  instr_decode #(.PC_W(PC_W)) u_decode (
    .ir_i        (ir_d),
    .dec_o       (dec),
    .off_b_o     (off_b),
    .off_bcond_o (off_bc)
  );

  assign pc_plus4 = pc_q + PC_STEP;
  assign is_mem   = (dec.cls == CLS_LDUR) || (dec.cls == CLS_STUR);
  assign bc_taken = cond_taken(flag_q[3], flag_q[2], flag_q[0], dec.cond);
  // MEM-state controls are driven on entry from EXEC and while waiting.
  assign mem_stay = ((state_q == EXEC) && is_mem) || ((state_q == MEM) && !sram_ready);

  assign unused_bits = ^{rd1_data, flag_q[1]};

  // Control FSM: next state, PC/IR/flags and the registered outputs for the
  // state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      flag_q       <= '0;
      imem_req_q   <= 1'b0;
      read1_q      <= '0;
      read2_q      <= '0;
      write_addr_q <= '0;
      write_en_q   <= 1'b0;
      alu_q        <= ALU_PASS;
      bsel_q       <= 1'b0;
      const_q      <= '0;
      dsel_q       <= 1'b0;
      cs_q         <= 1'b0;
      sram_wr_q    <= 1'b0;
      to_sram_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      write_en_q <= 1'b0;
      alu_q      <= ALU_PASS;
      bsel_q     <= 1'b0;
      const_q    <= '0;
      dsel_q     <= 1'b0;
      cs_q       <= 1'b0;
      sram_wr_q  <= 1'b0;
      to_sram_q  <= 1'b0;
      illegal_q  <= 1'b0;

      case (state_q)
        FETCH: begin
          if (fetch_acc) begin
            ir_q      <= instr;
            state_q   <= DECODE;
            read1_q   <= (dec.cls == CLS_BR) ? dec.rd : dec.rn;
            illegal_q <= (dec.cls == CLS_NOP);
            if (dec.cls == CLS_RTYPE) begin
              read2_q <= dec.rm;
            end else if (dec.cls == CLS_STUR) begin
              read2_q <= dec.rd;
            end
          end else begin
            imem_req_q <= run;
          end
        end

        DECODE: begin
          if (dec.cls == CLS_NOP) begin
            pc_q       <= pc_plus4;
            state_q    <= FETCH;
            imem_req_q <= run;
          end else begin
            state_q <= EXEC;
            alu_q   <= dec.alu_fn;
            if (is_mem) begin
              bsel_q  <= 1'b1;
              const_q <= 32'(dec.dt);
            end else if (dec.alu_fn == ALU_LSL) begin
              bsel_q  <= 1'b1;
              const_q <= 32'(dec.shamt);
            end
          end
        end

        EXEC: begin
          case (dec.cls)
            CLS_RTYPE: begin
              if (dec.sets_flags) begin
                flag_q <= FLAGS;
              end
              state_q      <= WB;
              write_en_q   <= 1'b1;
              write_addr_q <= dec.rd;
            end
            CLS_LDUR, CLS_STUR: state_q <= MEM;
            CLS_B: begin
              pc_q       <= pc_q + off_b;
              state_q    <= FETCH;
              imem_req_q <= run;
            end
            CLS_BCOND: begin
              pc_q       <= bc_taken ? (pc_q + off_bc) : pc_plus4;
              state_q    <= FETCH;
              imem_req_q <= run;
            end
            CLS_BR: begin
              pc_q       <= rd1_data[PC_W-1:0];
              state_q    <= FETCH;
              imem_req_q <= run;
            end
            default: begin
              state_q    <= FETCH;
              imem_req_q <= run;
            end
          endcase
        end

        MEM: begin
          if (sram_ready) begin
            if (dec.cls == CLS_STUR) begin
              pc_q       <= pc_plus4;
              state_q    <= FETCH;
              imem_req_q <= run;
            end else begin
              state_q      <= WB;
              write_en_q   <= 1'b1;
              write_addr_q <= dec.rd;
              dsel_q       <= 1'b1;
            end
          end
        end

        WB: begin
          pc_q       <= pc_plus4;
          state_q    <= FETCH;
          imem_req_q <= run;
        end

        default: begin
          state_q <= FETCH;
        end
      endcase

      // SRAM access controls with the ALU address (Rn + DT) held steady.
      if (mem_stay) begin
        cs_q      <= 1'b1;
        alu_q     <= ALU_ADD;
        bsel_q    <= 1'b1;
        const_q   <= 32'(dec.dt);
        dsel_q    <= (dec.cls == CLS_LDUR);
        sram_wr_q <= (dec.cls == CLS_STUR);
        to_sram_q <= (dec.cls == CLS_STUR);
      end
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign read1_addr   = read1_q;
  assign read2_addr   = read2_q;
  assign write_addr   = write_addr_q;
  assign write_en     = write_en_q;
  assign alu_function = alu_q;
  assign Bselect      = bsel_q;
  assign constant     = const_q;
  assign Dselect      = dsel_q;
  assign SRAM_CS      = cs_q;
  assign SRAM_write   = sram_wr_q;
  assign writeToSRAM  = to_sram_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  read1_addr, read2_addr, write_addr;
  logic        write_en;
  logic [63:0] rd1_data;
  logic [2:0]  alu_function;
  logic [3:0]  FLAGS;
  logic        Bselect;
  logic [31:0] constant;
  logic        Dselect, SRAM_CS, SRAM_write, writeToSRAM, sram_ready, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instruction observations, indexed by cycle offset from the fetch cycle.
  int          obs_lat, obs_we_cnt, obs_we_idx, obs_cs_cnt, obs_sw_cnt, obs_wts_cnt;
  int          obs_ill_cnt, obs_dsel_cnt;
  logic [4:0]  obs_we_addr, obs_r1, obs_r2;
  logic [2:0]  obs_alu;
  logic        obs_bsel;
  logic [31:0] obs_const;

  multicycle_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .pc           (pc),
    .read1_addr   (read1_addr),
    .read2_addr   (read2_addr),
    .write_addr   (write_addr),
    .write_en     (write_en),
    .rd1_data     (rd1_data),
    .alu_function (alu_function),
    .FLAGS        (FLAGS),
    .Bselect      (Bselect),
    .constant     (constant),
    .Dselect      (Dselect),
    .SRAM_CS      (SRAM_CS),
    .SRAM_write   (SRAM_write),
    .writeToSRAM  (writeToSRAM),
    .sram_ready   (sram_ready),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fetch one instruction (once imem_req is up) and follow it until the next
  // fetch request; sram_ready is raised in the mem_wait-th SRAM_CS cycle.
  task automatic exec_instr(input logic [31:0] word, input int mem_wait);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("imem_req_before_fetch", 32'(imem_req), 32'd1);
    obs_we_cnt = 0; obs_we_idx = -1; obs_cs_cnt = 0; obs_sw_cnt = 0;
    obs_wts_cnt = 0; obs_ill_cnt = 0; obs_dsel_cnt = 0; obs_we_addr = '0;
    obs_r1 = '0; obs_r2 = '0; obs_alu = '0; obs_bsel = 1'b0; obs_const = '0;
    instr = word;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    instr = 32'h0;
    obs_lat = 1;
    while (imem_req !== 1'b1 && obs_lat < 40) begin
      if (obs_lat == 1) begin
        obs_r1 = read1_addr;
        obs_r2 = read2_addr;
      end
      if (obs_lat == 2) begin
        obs_alu   = alu_function;
        obs_bsel  = Bselect;
        obs_const = constant;
      end
      if (write_en) begin
        obs_we_cnt++;
        obs_we_idx  = obs_lat;
        obs_we_addr = write_addr;
      end
      if (SRAM_CS)     obs_cs_cnt++;
      if (SRAM_write)  obs_sw_cnt++;
      if (writeToSRAM) obs_wts_cnt++;
      if (illegal)     obs_ill_cnt++;
      if (Dselect)     obs_dsel_cnt++;
      sram_ready = SRAM_CS && (obs_cs_cnt >= mem_wait);
      @(negedge clk);
      obs_lat++;
    end
    sram_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; run = 1'b1; imem_ready = 1'b0; instr = '0;
    rd1_data = '0; FLAGS = '0; sram_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_imem_addr", imem_addr, 32'h0);
    check_eq("rst_strobes",
             32'({imem_req, write_en, Bselect, Dselect, SRAM_CS, SRAM_write, writeToSRAM, illegal}),
             32'h0);
    check_eq("rst_alu_const", constant | 32'(alu_function), 32'h0);
    check_eq("rst_addrs", 32'({read1_addr, read2_addr, write_addr}), 32'h0);
    rst_n = 1'b1;

    // ADD X3,X1,X2
    exec_instr(32'h8B02_0023, 1);
    check_eq("add_lat", 32'(obs_lat), 32'd4);
    check_eq("add_r1", 32'(obs_r1), 32'd1);
    check_eq("add_r2", 32'(obs_r2), 32'd2);
    check_eq("add_alu", 32'(obs_alu), 32'd1);
    check_eq("add_bsel", 32'(obs_bsel), 32'd0);
    check_eq("add_we_cnt", 32'(obs_we_cnt), 32'd1);
    check_eq("add_we_idx", 32'(obs_we_idx), 32'd3);
    check_eq("add_we_addr", 32'(obs_we_addr), 32'd3);
    check_eq("add_pc", pc, 32'h4);

    // STURW interrupted by reset while waiting in MEM
    instr = 32'hB800_4047;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stur_pre_rst_cs", 32'({SRAM_CS, SRAM_write, writeToSRAM}), 32'h7);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midmem_rst_cs", 32'(SRAM_CS), 32'd0);
    check_eq("midmem_rst_sw", 32'(SRAM_write), 32'd0);
    check_eq("midmem_rst_pc", pc, 32'h0);
    rst_n = 1'b1;

    // LDURSW X5,[X1,#8] with 3-cycle SRAM
    exec_instr(32'hB880_8025, 3);
    check_eq("ldur_lat", 32'(obs_lat), 32'd7);
    check_eq("ldur_r1", 32'(obs_r1), 32'd1);
    check_eq("ldur_alu", 32'(obs_alu), 32'd1);
    check_eq("ldur_bsel", 32'(obs_bsel), 32'd1);
    check_eq("ldur_const", obs_const, 32'd8);
    check_eq("ldur_cs_cnt", 32'(obs_cs_cnt), 32'd3);
    check_eq("ldur_dsel_cnt", 32'(obs_dsel_cnt), 32'd4);
    check_eq("ldur_sw_cnt", 32'(obs_sw_cnt), 32'd0);
    check_eq("ldur_we_idx", 32'(obs_we_idx), 32'd6);
    check_eq("ldur_we_addr", 32'(obs_we_addr), 32'd5);
    check_eq("ldur_pc", pc, 32'h4);

    // STURW W7,[X2,#4], immediate SRAM
    exec_instr(32'hB800_4047, 1);
    check_eq("stur_lat", 32'(obs_lat), 32'd4);
    check_eq("stur_r1", 32'(obs_r1), 32'd2);
    check_eq("stur_r2", 32'(obs_r2), 32'd7);
    check_eq("stur_const", obs_const, 32'd4);
    check_eq("stur_cs_sw_wts", 32'({8'(obs_cs_cnt), 8'(obs_sw_cnt), 8'(obs_wts_cnt)}), 32'h010101);
    check_eq("stur_we_dsel", 32'(obs_we_cnt + obs_dsel_cnt), 32'd0);
    check_eq("stur_pc", pc, 32'h8);

    // SUB with clear flags, then B.cond GT (+16) taken
    FLAGS = 4'b0000;
    exec_instr(32'hCB02_0024, 1);
    check_eq("sub_alu", 32'(obs_alu), 32'd2);
    check_eq("sub_we_addr", 32'(obs_we_addr), 32'd4);
    check_eq("sub_pc", pc, 32'hC);
    exec_instr(32'h5400_008C, 1);
    check_eq("bgt_taken_lat", 32'(obs_lat), 32'd3);
    check_eq("bgt_taken_pc", pc, 32'h1C);
    check_eq("bgt_we", 32'(obs_we_cnt), 32'd0);

    // SUB with Z set; live FLAGS cleared before B.cond so only latched Z counts
    FLAGS = 4'b0100;
    exec_instr(32'hCB02_0024, 1);
    check_eq("sub2_pc", pc, 32'h20);
    FLAGS = 4'b0000;
    exec_instr(32'h5400_008C, 1);
    check_eq("bgt_not_taken_pc", pc, 32'h24);

    // BR to 10h, B -1 word to 0Ch, BR to 40h
    rd1_data = 64'h10;
    exec_instr(32'hD600_001E, 1);
    check_eq("br_r1", 32'(obs_r1), 32'd30);
    check_eq("br_lat", 32'(obs_lat), 32'd3);
    check_eq("br_pc10", pc, 32'h10);
    exec_instr(32'h17FF_FFFF, 1);
    check_eq("b_back_pc", pc, 32'hC);
    check_eq("b_we", 32'(obs_we_cnt), 32'd0);
    rd1_data = 64'hFFFF_0000_0000_0040;
    exec_instr(32'hD600_001E, 1);
    check_eq("br_pc40", pc, 32'h40);
    check_eq("br_we", 32'(obs_we_cnt), 32'd0);

    // NOP words: all-zero and unknown
    exec_instr(32'h0000_0000, 1);
    check_eq("nop0_lat", 32'(obs_lat), 32'd2);
    check_eq("nop0_ill", 32'(obs_ill_cnt), 32'd1);
    check_eq("nop0_we_cs", 32'(obs_we_cnt + obs_cs_cnt), 32'd0);
    check_eq("nop0_pc", pc, 32'h44);
    exec_instr(32'hFFFF_FFFF, 1);
    check_eq("nopF_ill", 32'(obs_ill_cnt), 32'd1);
    check_eq("nopF_we_cs", 32'(obs_we_cnt + obs_cs_cnt), 32'd0);
    check_eq("nopF_pc", pc, 32'h48);
    check_eq("nopF_ill_after", 32'(illegal), 32'd0);

    // LSL X6,X1,#3
    exec_instr(32'hD360_0C26, 1);
    check_eq("lsl_alu", 32'(obs_alu), 32'd6);
    check_eq("lsl_bsel", 32'(obs_bsel), 32'd1);
    check_eq("lsl_const", obs_const, 32'd3);
    check_eq("lsl_we_addr", 32'(obs_we_addr), 32'd6);
    check_eq("lsl_pc", pc, 32'h4C);

    // run low: instruction offered on the fetch port must not be taken
    run = 1'b0;
    instr = 32'h8B02_0023;
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("run_low_req", 32'(imem_req), 32'd0);
    check_eq("run_low_pc", pc, 32'h4C);
    check_eq("run_low_we", 32'(write_en), 32'd0);
    imem_ready = 1'b0;
    run = 1'b1;

    // PC wrap-around
    rd1_data = 64'hFFFF_FFFC;
    exec_instr(32'hD600_001E, 1);
    check_eq("wrap_br_lat", 32'(obs_lat), 32'd3);
    check_eq("wrap_br_pc", pc, 32'hFFFF_FFFC);
    exec_instr(32'h0000_0000, 1);
    check_eq("wrap_nop_pc", pc, 32'h0);
    check_eq("wrap_imem_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
